// File: rtl/bch_parallel_encoder.sv
// Systematic BCH encoder: DataWidth-bit unrolled LFSR, message pass-through then parity.
// Optional BCH_ENC_ABORT_EN adds iAbort to discard the current codeword.
module bch_parallel_encoder #(
  parameter int DataWidth     = 8,
  parameter int ParityLength  = 168,
  parameter int MessageLength = 8192,
  parameter logic [0:ParityLength] GenPoly =
    169'b1100011001001101001001011010010000001010100100010101010000111100111110110010110000100000001101100011000011111011010100011001110110100011110100100001001101010100010111001
) (
  input  logic                 iClock,
  input  logic                 iReset,
`ifdef BCH_ENC_ABORT_EN
  input  logic                 iAbort,
`endif
  input  logic [DataWidth-1:0] iMessage,
  input  logic                 iMessageValid,
  output logic                 oMessageReady,
  output logic [DataWidth-1:0] oData,
  output logic                 oDataValid,
  input  logic                 iDataReady,
  output logic                 oParityPhase,
  output logic                 oLast
);

  localparam int MsgBeats = MessageLength / DataWidth;
  localparam int ParBeats = ParityLength / DataWidth;
  localparam int MaxLen =
    (MessageLength > ParityLength) ? MessageLength : ParityLength;
  localparam int CountWidth = $clog2(MaxLen / DataWidth + 1);
  localparam logic [CountWidth-1:0] MsgLastCount =
    CountWidth'(MsgBeats - 1);
  localparam logic [CountWidth-1:0] ParLastCount =
    CountWidth'(ParBeats - 1);

  typedef enum logic {
    StMsg,
    StParity
  } state_t;

  // Feedback taps x^0..x^(ParityLength-1); x^ParityLength is implicit.
  function automatic logic [ParityLength-1:0] tapsOf();
    logic [ParityLength-1:0] t;
    t = '0;
    for (int c = 0; c < ParityLength; c++) begin
      t[c] = GenPoly[c];
    end
    return t;
  endfunction

  localparam logic [ParityLength-1:0] Taps = tapsOf();

  function automatic logic [ParityLength-1:0] stepBeat(
    input logic [ParityLength-1:0] p,
    input logic [DataWidth-1:0]    d
  );
    logic [ParityLength-1:0] r;
    logic                    fb;
    r = p;
    for (int i = DataWidth - 1; i >= 0; i--) begin
      fb = d[i] ^ r[ParityLength-1];
      r  = {r[ParityLength-2:0], 1'b0};
      r  = r ^ ({ParityLength{fb}} & Taps);
    end
    return r;
  endfunction

  state_t                  state;
  state_t                  stateNext;
  logic [CountWidth-1:0]   count;
  logic [CountWidth-1:0]   countNext;
  logic [ParityLength-1:0] parity;
  logic [ParityLength-1:0] parityNext;
  logic                    kill;
  logic                    live;
  logic                    msgFire;
  logic                    parFire;

`ifdef BCH_ENC_ABORT_EN
  assign kill = iReset | iAbort;
`else
  assign kill = iReset;
`endif

  assign live    = ~kill;
  assign msgFire = live & (state == StMsg) & iMessageValid & iDataReady;
  assign parFire = live & (state == StParity) & iDataReady;

  always_ff @(posedge iClock) begin
    if (kill) begin
      state  <= StMsg;
      count  <= '0;
      parity <= '0;
    end else begin
      state  <= stateNext;
      count  <= countNext;
      parity <= parityNext;
    end
  end

  always_comb begin
    stateNext     = state;
    countNext     = count;
    parityNext    = parity;
    oMessageReady = 1'b0;
    oDataValid    = 1'b0;
    oParityPhase  = 1'b0;
    oLast         = 1'b0;
    oData         = parity[ParityLength-1 -: DataWidth];
    unique case (state)
      StMsg: begin
        oData = iMessage;
        if (live) begin
          oMessageReady = iDataReady;
          oDataValid    = iMessageValid;
        end
        if (msgFire) begin
          parityNext = stepBeat(parity, iMessage);
          countNext  = count + 1'b1;
          if (count == MsgLastCount) begin
            stateNext = StParity;
            countNext = '0;
          end
        end
      end
      StParity: begin
        if (live) begin
          oDataValid   = 1'b1;
          oParityPhase = 1'b1;
          oLast        = (count == ParLastCount);
        end
        if (parFire) begin
          parityNext = {parity[ParityLength-DataWidth-1:0],
                        {DataWidth{1'b0}}};
          countNext  = count + 1'b1;
          if (count == ParLastCount) begin
            parityNext = '0;
            countNext  = '0;
            stateNext  = StMsg;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bch_parallel_encoder.sv
// Randomised bench for bch_parallel_encoder against a polynomial-division model.
// Build with +define+BCH_ENC_ABORT_EN to exercise the abort input.
module tb_bch_parallel_encoder;

  localparam int Dw = 8;
  localparam int Pl = 168;
  localparam int Ml = 8192;
  localparam int MsgBeats = Ml / Dw;
  localparam int ParBeats = Pl / Dw;
  localparam logic [0:Pl] Gen =
    169'b1100011001001101001001011010010000001010100100010101010000111100111110110010110000100000001101100011000011111011010100011001110110100011110100100001001101010100010111001;

  logic          clk;
  logic          iReset;
  logic [Dw-1:0] iMessage;
  logic          iMessageValid;
  logic          oMessageReady;
  logic [Dw-1:0] oData;
  logic          oDataValid;
  logic          iDataReady;
  logic          oParityPhase;
  logic          oLast;
`ifdef BCH_ENC_ABORT_EN
  logic          iAbort;
`endif

  bch_parallel_encoder dut (
    .iClock        (clk),
    .iReset        (iReset),
`ifdef BCH_ENC_ABORT_EN
    .iAbort        (iAbort),
`endif
    .iMessage      (iMessage),
    .iMessageValid (iMessageValid),
    .oMessageReady (oMessageReady),
    .oData         (oData),
    .oDataValid    (oDataValid),
    .iDataReady    (iDataReady),
    .oParityPhase  (oParityPhase),
    .oLast         (oLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared;
  int nMismatched;
  int cwNum;

  logic [Dw-1:0] curMsg [MsgBeats];
  logic [Dw-1:0] expPar [ParBeats];
  logic [Dw-1:0] obsPar [ParBeats];
  bit            div    [Ml+Pl];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Remainder of m(x)*x^Pl mod g(x); first serial bit is the top coefficient.
  task automatic computeExpected();
    for (int i = 0; i < Ml + Pl; i++) div[i] = 1'b0;
    for (int j = 0; j < Ml; j++) begin
      div[Pl + Ml - 1 - j] = curMsg[j / Dw][Dw - 1 - (j % Dw)];
    end
    for (int d = Ml + Pl - 1; d >= Pl; d--) begin
      if (div[d]) begin
        for (int c = 0; c <= Pl; c++) begin
          div[d - Pl + c] = div[d - Pl + c] ^ Gen[c];
        end
      end
    end
    for (int k = 0; k < ParBeats; k++) begin
      for (int b = 0; b < Dw; b++) begin
        expPar[k][Dw - 1 - b] = div[Pl - 1 - Dw * k - b];
      end
    end
  endtask

  task automatic fillMsg(input int mode);
    for (int i = 0; i < MsgBeats; i++) begin
      case (mode)
        0: curMsg[i] = '0;
        1: curMsg[i] = (i == MsgBeats - 1) ? 8'h01 : 8'h00;
        default: curMsg[i] = Dw'($urandom);
      endcase
    end
  endtask

  // Entered and left at posedge+1; a full codeword leaves no idle cycle.
  task automatic runCodeword(input bit stall, input int rstParBeat,
                             input int abortMsgBeat);
    int idx;
    int pcount;
    int msgErr;
    int hsErr;
    int cycles;
    bit inPar;
    logic [ParBeats-1:0] lastMask;
    idx = 0;
    pcount = 0;
    msgErr = 0;
    hsErr = 0;
    cycles = 0;
    lastMask = '0;
    cwNum++;
    computeExpected();
    while (pcount < ParBeats && cycles < 20000) begin
      inPar = (idx == MsgBeats);
      if (inPar && pcount == rstParBeat) begin
        iReset = 1'b1;
        iMessageValid = 1'b1;
        iDataReady = 1'b1;
        @(negedge clk);
        check($sformatf("cw%0d_rstQuiet", cwNum),
              {oDataValid, oMessageReady, oParityPhase, oLast}, 0);
        @(posedge clk);
        #1;
        iReset = 1'b0;
        iMessageValid = 1'b0;
        return;
      end
`ifdef BCH_ENC_ABORT_EN
      if (!inPar && idx == abortMsgBeat) begin
        iAbort = 1'b1;
        iMessageValid = 1'b1;
        iDataReady = 1'b1;
        iMessage = curMsg[idx];
        @(negedge clk);
        check($sformatf("cw%0d_abortQuiet", cwNum),
              {oDataValid, oMessageReady}, 0);
        @(posedge clk);
        #1;
        iAbort = 1'b0;
        iMessageValid = 1'b0;
        return;
      end
`endif
      iMessageValid = inPar ? 1'b0 : (stall ? 1'($urandom) : 1'b1);
      iDataReady = stall ? 1'($urandom) : 1'b1;
      iMessage = (!inPar && iMessageValid) ? curMsg[idx] : Dw'($urandom);
      @(negedge clk);
      if (!inPar) begin
        if (oDataValid !== iMessageValid || oMessageReady !== iDataReady ||
            oParityPhase !== 1'b0 || oLast !== 1'b0)
          hsErr++;
        if (iMessageValid && iDataReady) begin
          if (oData !== curMsg[idx]) msgErr++;
          idx++;
        end
      end else begin
        if (oDataValid !== 1'b1 || oParityPhase !== 1'b1 ||
            oMessageReady !== 1'b0)
          hsErr++;
        if (iDataReady) begin
          obsPar[pcount] = oData;
          lastMask[pcount] = oLast;
          pcount++;
        end
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    check($sformatf("cw%0d_timeout", cwNum), 64'(pcount), 64'(ParBeats));
    check($sformatf("cw%0d_msgPass", cwNum), 64'(msgErr), 0);
    check($sformatf("cw%0d_handshake", cwNum), 64'(hsErr), 0);
    check($sformatf("cw%0d_lastMask", cwNum), 64'(lastMask),
          64'(1) << (ParBeats - 1));
    for (int k = 0; k < ParBeats; k++) begin
      check($sformatf("cw%0d_par%0d", cwNum, k), 64'(obsPar[k]),
            64'(expPar[k]));
    end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    cwNum = 0;
    iReset = 1'b1;
    iMessage = '0;
    iMessageValid = 1'b1;
    iDataReady = 1'b1;
`ifdef BCH_ENC_ABORT_EN
    iAbort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("resetQuiet", {oDataValid, oMessageReady, oParityPhase, oLast}, 0);
    @(posedge clk);
    #1;
    iReset = 1'b0;
    iMessageValid = 1'b0;
    @(negedge clk);
    check("idleReady", {oMessageReady, oDataValid, oParityPhase, oLast},
          4'b1000);
    @(posedge clk);
    #1;

    fillMsg(0);
    runCodeword(1'b0, -1, -1);
    fillMsg(1);
    runCodeword(1'b0, -1, -1);
    for (int n = 0; n < 20; n++) begin
      fillMsg(2);
      runCodeword(1'b0, -1, -1);
    end
    for (int n = 0; n < 2; n++) begin
      fillMsg(2);
      runCodeword(1'b1, -1, -1);
    end
    fillMsg(2);
    runCodeword(1'b0, 7, -1);
    fillMsg(0);
    runCodeword(1'b0, -1, -1);
`ifdef BCH_ENC_ABORT_EN
    fillMsg(2);
    runCodeword(1'b0, -1, 500);
    fillMsg(2);
    runCodeword(1'b0, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule
